// File: rtl/range_divider.sv
// Per-range multiplier-window generator: for K = 1..K_MAX it serially divides the
// range bounds by 10^K+1 and emits one clamped, division-ROM-format entry per K.
module range_divider #(
  parameter int WIDTH = 40,
  parameter int K_MAX = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_lo,
  input  logic [WIDTH-1:0] in_hi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [95:0]      out_entry,
  output logic             out_last,
  output logic             busy
);

  localparam int DW = WIDTH + 1;  // dividend / divisor width
  localparam int RW = WIDTH + 2;  // shifted partial remainder width
  localparam logic [3:0] K_LAST = 4'(K_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_DIV_HI, S_DIV_LO, S_CLAMP, S_EMIT
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       k_q;
  logic [WIDTH-1:0] lo_q, hi_q, lo_bound_q, hi_bound_q, q_hi_q, quot_q;
  logic [DW-1:0]    c_q, dvd_q, rem_q;
  logic [5:0]       cnt_q;
  logic [95:0]      entry_q, entry_d;
  logic             last_q;

  function automatic logic [DW-1:0] pow10(input logic [3:0] n);
    case (n)
      4'd0:    pow10 = DW'(64'd1);
      4'd1:    pow10 = DW'(64'd10);
      4'd2:    pow10 = DW'(64'd100);
      4'd3:    pow10 = DW'(64'd1000);
      4'd4:    pow10 = DW'(64'd10000);
      4'd5:    pow10 = DW'(64'd100000);
      4'd6:    pow10 = DW'(64'd1000000);
      4'd7:    pow10 = DW'(64'd10000000);
      4'd8:    pow10 = DW'(64'd100000000);
      4'd9:    pow10 = DW'(64'd1000000000);
      4'd10:   pow10 = DW'(64'd10000000000);
      4'd11:   pow10 = DW'(64'd100000000000);
      4'd12:   pow10 = DW'(64'd1000000000000);
      default: pow10 = '0;
    endcase
  endfunction

  logic [DW-1:0] pow_k, pow_km1;
  assign pow_k   = pow10(k_q);
  assign pow_km1 = pow10(k_q - 4'd1);

  // One restoring-division step: the sign of a single subtract decides the quotient bit.
  logic [RW-1:0]    rem_shift;
  logic [RW:0]      diff;
  logic             q_bit;
  logic [DW-1:0]    rem_next;
  logic [WIDTH-1:0] quot_next;
  logic             div_done;
  logic             unused_diff_hi;

  assign rem_shift      = {rem_q, dvd_q[DW-1]};
  assign diff           = {1'b0, rem_shift} - {2'b00, c_q};
  assign q_bit          = ~diff[RW];
  assign rem_next       = q_bit ? diff[DW-1:0] : rem_shift[DW-1:0];
  assign quot_next      = {quot_q[WIDTH-2:0], q_bit};
  assign div_done       = (cnt_q == 6'(DW - 1));
  assign unused_diff_hi = ^{diff[RW-1:DW], rem_shift[RW-1]};

  logic [WIDTH-1:0] xs, xe;
  logic             vld;

  always_comb begin
    xs      = (quot_q < lo_bound_q) ? lo_bound_q : quot_q;
    xe      = (q_hi_q < hi_bound_q) ? q_hi_q : hi_bound_q;
    vld     = (xs <= xe) && (lo_q <= hi_q);
    entry_d = '0;
    entry_d[80] = vld;
    if (vld) begin
      entry_d[39:0]  = 40'(xs);
      entry_d[79:40] = 40'(xe);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = S_SETUP;
      S_SETUP:  state_d = S_DIV_HI;
      S_DIV_HI: if (div_done) state_d = S_DIV_LO;
      S_DIV_LO: if (div_done) state_d = S_CLAMP;
      S_CLAMP:  state_d = S_EMIT;
      S_EMIT:   if (out_ready) state_d = (k_q == K_LAST) ? S_IDLE : S_SETUP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_EMIT);
    busy      = (state_q != S_IDLE);
  end

  assign out_entry = entry_q;
  assign out_last  = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      lo_bound_q <= '0;
      hi_bound_q <= '0;
      q_hi_q     <= '0;
      quot_q     <= '0;
      c_q        <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      entry_q    <= '0;
      last_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            lo_q <= in_lo;
            hi_q <= in_hi;
            k_q  <= 4'd1;
          end
        end
        S_SETUP: begin
          c_q        <= pow_k + DW'(1);
          lo_bound_q <= WIDTH'(pow_km1);
          hi_bound_q <= WIDTH'(pow_k - DW'(1));
          dvd_q      <= {1'b0, hi_q};
          rem_q      <= '0;
          quot_q     <= '0;
          cnt_q      <= '0;
        end
        S_DIV_HI: begin
          if (div_done) begin
            // Second pass divides lo + c - 1 so the floor quotient becomes ceil(lo / c).
            q_hi_q <= quot_next;
            dvd_q  <= {1'b0, lo_q} + c_q - DW'(1);
            rem_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
          end else begin
            dvd_q  <= {dvd_q[DW-2:0], 1'b0};
            rem_q  <= rem_next;
            quot_q <= quot_next;
            cnt_q  <= cnt_q + 6'd1;
          end
        end
        S_DIV_LO: begin
          dvd_q  <= {dvd_q[DW-2:0], 1'b0};
          rem_q  <= rem_next;
          quot_q <= quot_next;
          cnt_q  <= cnt_q + 6'd1;
        end
        S_CLAMP: begin
          entry_q <= entry_d;
          last_q  <= (k_q == K_LAST);
        end
        S_EMIT: begin
          if (out_ready && (k_q != K_LAST)) k_q <= k_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
